// File: rtl/serial_uart_bridge.sv
// Show-ahead synchronous FIFO shared by both directions of the UART bridge.
// Latency: an accepted push is visible at the head one clock later; head is zero while empty.
// Backpressure: push refused when full, pop ignored when empty, both judged on the pre-edge count.
module serial_uart_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    // Gated so the head reads zero out of reset, when the storage is still unwritten.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

// Byte-serial CPU port to 8N1 UART bridge with TX and RX FIFOs.
// Latency: write at edge k pops at k+1 and drives the start bit from k+1; RX byte pushed at mid stop bit.
// Backpressure: cpu_ready_out drops when TX FIFO full (extra writes dropped, sticky flag); RX overrun drops.
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_wdata_in,
    input  logic       cpu_wren_in,
    output logic       cpu_ready_out,
    output logic [7:0] cpu_rdata_out,
    output logic       cpu_valid_out,
    input  logic       cpu_rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       tx_overflow_out,
    output logic       rx_overrun_out,
    output logic       frame_error_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

    // ---------------- TX path ----------------
    logic          tx_full, tx_empty, tx_pop;
    logic [7:0]    tx_head;
    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;
    logic          tx_overflow_q;

    serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk_i      (clock),
        .rst_n_i    (reset),
        .push_i     (cpu_wren_in),
        .push_dat_i (cpu_wdata_in),
        .pop_i      (tx_pop),
        .head_dat_o (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    // TX framing: the line value for the next bit period is computed one edge ahead so uart_tx_out is a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_line_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                tx_line_d = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_line_d  = 1'b1;
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX state registers; reset forces the line high immediately, aborting any frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_line_q     <= 1'b1;
            tx_overflow_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_line_q     <= tx_line_d;
            tx_overflow_q <= tx_overflow_q | (cpu_wren_in & tx_full);
        end
    end

    // ---------------- RX path ----------------
    logic          rx_meta_q, rx_sync_q;
    logic [2:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_push, rx_frame_err;
    logic          rx_full, rx_empty;
    logic          rx_overrun_q, frame_error_q;

    serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk_i      (clock),
        .rst_n_i    (reset),
        .push_i     (rx_push),
        .push_dat_i (rx_shift_q),
        .pop_i      (cpu_rden_in),
        .head_dat_o (cpu_rdata_out),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    // RX sampling: half a bit after the synced falling edge confirms the start bit, then one sample per bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_push      = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_err = 1'b1;
                        rx_state_d   = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX synchronizer, state and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_overrun_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= uart_rx_in;
            rx_sync_q     <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_overrun_q  <= rx_overrun_q | (rx_push & rx_full);
            frame_error_q <= frame_error_q | rx_frame_err;
        end
    end

    assign cpu_ready_out   = !tx_full;
    assign cpu_valid_out   = !rx_empty;
    assign uart_tx_out     = tx_line_q;
    assign tx_overflow_out = tx_overflow_q;
    assign rx_overrun_out  = rx_overrun_q;
    assign frame_error_out = frame_error_q;
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Scoreboard bench for serial_uart_bridge at CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Stimulus pushes expected TX-line and CPU-read bytes; two monitors pop and compare.
// Inputs change 1 time unit after a rising edge; outputs are sampled there or on the falling edge.
module tb_serial_uart_bridge;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cpu_wdata_in = 8'h00;
    logic       cpu_wren_in = 1'b0;
    logic       cpu_rden_in = 1'b0;
    logic       cpu_ready_out, cpu_valid_out, uart_tx_out;
    logic       tx_overflow_out, rx_overrun_out, frame_error_out;
    logic [7:0] cpu_rdata_out;
    logic       rx_drv = 1'b1;
    logic       lb_en = 1'b0;
    logic       uart_rx_in;

    int n_checks = 0;
    int n_fail = 0;
    int tx_frames = 0;
    int reset_epoch = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    assign uart_rx_in = lb_en ? uart_tx_out : rx_drv;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_wdata_in    (cpu_wdata_in),
        .cpu_wren_in     (cpu_wren_in),
        .cpu_ready_out   (cpu_ready_out),
        .cpu_rdata_out   (cpu_rdata_out),
        .cpu_valid_out   (cpu_valid_out),
        .cpu_rden_in     (cpu_rden_in),
        .uart_rx_in      (uart_rx_in),
        .uart_tx_out     (uart_tx_out),
        .tx_overflow_out (tx_overflow_out),
        .rx_overrun_out  (rx_overrun_out),
        .frame_error_out (frame_error_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (!reset) reset_epoch <= reset_epoch + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        cpu_wdata_in = b;
        cpu_wren_in  = 1'b1;
        cyc(1);
        cpu_wren_in  = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopv);
        rx_drv = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            cyc(CPB);
        end
        rx_drv = stopv;
        cyc(CPB);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (cpu_valid_out !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        n_checks++;
        if (cpu_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got no cpu_valid_out within %0d cycles, expected 1", name, budget);
        end
    endtask

    // TX line monitor: decodes each frame at mid-bit and checks it against the expected queue.
    initial begin : tx_mon
        logic [7:0] b;
        logic [7:0] e;
        logic       stopb;
        int         ep;
        b = 8'h00;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && uart_tx_out === 1'b0) begin
                ep = reset_epoch;
                repeat (2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = uart_tx_out;
                end
                repeat (CPB) @(negedge clock);
                stopb = uart_tx_out;
                if (ep == reset_epoch) begin
                    tx_frames++;
                    chk("tx_stop_bit", {31'd0, stopb}, 32'd1);
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx_byte", {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    end

    // CPU read monitor: every accepted pop must deliver the next expected byte.
    initial begin : rx_mon
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (cpu_rden_in === 1'b1 && cpu_valid_out === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected_read: got 0x%0h, expected no data", cpu_rdata_out);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_byte", {24'd0, cpu_rdata_out}, {24'd0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] pat;
        logic [7:0] rx_pat [9];
        logic       e;
        int         lows;
        int         f0;
        rx_pat = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hF0, 8'h0F, 8'hC3, 8'h7E, 8'h99};

        // 1. reset state, then reset in the middle of a TX frame
        cyc(2);
        chk("rst_tx_line", {31'd0, uart_tx_out}, 32'd1);
        chk("rst_ready", {31'd0, cpu_ready_out}, 32'd1);
        chk("rst_valid", {31'd0, cpu_valid_out}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata_out}, 32'd0);
        chk("rst_flags", {29'd0, tx_overflow_out, rx_overrun_out, frame_error_out}, 32'd0);
        reset = 1'b1;
        cyc(1);
        wr_byte(8'h55);
        cyc(10);
        chk("mid_frame_line_low_before_reset", {31'd0, uart_tx_out}, 32'd0);
        reset = 1'b0;
        cyc(1);
        chk("rst_mid_frame_line_high", {31'd0, uart_tx_out}, 32'd1);
        cyc(1);
        chk("rst_mid_frame_ready", {31'd0, cpu_ready_out}, 32'd1);
        chk("rst_mid_frame_valid", {31'd0, cpu_valid_out}, 32'd0);
        chk("rst_mid_frame_flags", {29'd0, tx_overflow_out, rx_overrun_out, frame_error_out}, 32'd0);
        reset = 1'b1;
        lows = 0;
        repeat (45) begin
            cyc(1);
            if (uart_tx_out !== 1'b1) lows++;
        end
        chk("rst_no_partial_bits", lows, 32'd0);

        // 2. exact TX waveform of 0xA5 written at edge k
        pat = 8'hA5;
        exp_tx.push_back(8'hA5);
        wr_byte(8'hA5);
        for (int j = 0; j <= 41; j++) begin
            if (j >= 1 && j <= 4) e = 1'b0;
            else if (j >= 5 && j <= 36) e = pat[(j - 5) / 4];
            else e = 1'b1;
            chk("tx_a5_waveform", {31'd0, uart_tx_out}, {31'd0, e});
            if (j < 41) cyc(1);
        end

        // 3. TX FIFO fill: ten writes on consecutive edges, the tenth is dropped
        f0 = tx_frames;
        for (int i = 0; i < 10; i++) begin
            cpu_wdata_in = 8'(i * 17);
            cpu_wren_in  = 1'b1;
            if (i < 9) exp_tx.push_back(8'(i * 17));
            cyc(1);
            if (i == 7) chk("tx_ready_before_full", {31'd0, cpu_ready_out}, 32'd1);
            if (i == 8) begin
                chk("tx_ready_full", {31'd0, cpu_ready_out}, 32'd0);
                chk("tx_overflow_before_drop", {31'd0, tx_overflow_out}, 32'd0);
            end
            if (i == 9) chk("tx_overflow_set", {31'd0, tx_overflow_out}, 32'd1);
        end
        cpu_wren_in = 1'b0;
        cyc(10 * 41 + 20);
        chk("tx_frames_emitted", tx_frames - f0, 32'd9);
        chk("tx_queue_drained", exp_tx.size(), 32'd0);
        chk("tx_ready_after_drain", {31'd0, cpu_ready_out}, 32'd1);
        chk("tx_overflow_sticky", {31'd0, tx_overflow_out}, 32'd1);

        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("overflow_cleared_by_reset", {31'd0, tx_overflow_out}, 32'd0);

        // 6. one-clock glitch on the RX line
        rx_drv = 1'b0;
        cyc(1);
        rx_drv = 1'b1;
        cyc(20);
        chk("glitch_no_push", {31'd0, cpu_valid_out}, 32'd0);
        chk("glitch_no_flags", {30'd0, rx_overrun_out, frame_error_out}, 32'd0);

        // read of an empty RX FIFO must not move the pointers (loopback below would then misread)
        cpu_rden_in = 1'b1;
        cyc(1);
        cpu_rden_in = 1'b0;
        chk("rden_empty_ignored", {31'd0, cpu_valid_out}, 32'd0);

        // 4. loopback of 0x3C
        lb_en = 1'b1;
        exp_tx.push_back(8'h3C);
        exp_rx.push_back(8'h3C);
        wr_byte(8'h3C);
        wait_valid(100, "loopback_valid");
        chk("loopback_rdata", {24'd0, cpu_rdata_out}, 32'h3C);
        cpu_rden_in = 1'b1;
        cyc(1);
        cpu_rden_in = 1'b0;
        chk("loopback_valid_cleared", {31'd0, cpu_valid_out}, 32'd0);
        cyc(20);
        lb_en = 1'b0;
        cyc(4);

        // 5a. nine frames into an unread RX FIFO
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_rx.push_back(rx_pat[i]);
            send_rx(rx_pat[i], 1'b1);
            if (i == 7) begin
                cyc(4);
                chk("rx_no_overrun_at_depth", {31'd0, rx_overrun_out}, 32'd0);
            end
        end
        cyc(6);
        chk("rx_overrun_set", {31'd0, rx_overrun_out}, 32'd1);
        chk("rx_valid_when_full", {31'd0, cpu_valid_out}, 32'd1);
        cpu_rden_in = 1'b1;
        cyc(8);
        cpu_rden_in = 1'b0;
        chk("rx_empty_after_reads", {31'd0, cpu_valid_out}, 32'd0);
        chk("rx_all_bytes_read", exp_rx.size(), 32'd0);

        // 5b. frame error with the line held low afterwards
        chk("frame_error_clear_before", {31'd0, frame_error_out}, 32'd0);
        send_rx(8'hFF, 1'b0);
        cyc(20);
        chk("frame_error_set", {31'd0, frame_error_out}, 32'd1);
        chk("frame_error_no_push", {31'd0, cpu_valid_out}, 32'd0);
        rx_drv = 1'b1;
        cyc(40);
        chk("no_frame_while_line_low", {31'd0, cpu_valid_out}, 32'd0);
        exp_rx.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        wait_valid(20, "rx_recovery_valid");
        cpu_rden_in = 1'b1;
        cyc(1);
        cpu_rden_in = 1'b0;
        cyc(2);
        chk("rx_recovery_read", exp_rx.size(), 32'd0);
        chk("frame_error_sticky", {31'd0, frame_error_out}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
